// File: rtl/alu_result_pipe.sv
// Elastic chain of STAGES result registers between the ALU and writeback.
// Valid/ready flow control, synchronous flush and a combinational bypass port.
module alu_result_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic                              in_wen,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [TAG_W-1:0]                  out_tag,
  output logic                              out_wen,
  input  logic [TAG_W-1:0]                  fwd_tag,
  output logic                              fwd_hit,
  output logic [DATA_W-1:0]                 fwd_data,
  output logic [$clog2(STAGES+1)-1:0]       occupancy
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] wen_q;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_wen;
  logic [DATA_W-1:0] src_data [STAGES];
  logic [TAG_W-1:0]  src_tag  [STAGES];

  // A stage can take a new entry if it is empty or everything ahead moves.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !valid_q[k] || rdy[k+1];
    end
  end

  always_comb begin
    src_valid   = '0;
    src_wen     = '0;
    src_valid[0] = in_valid;
    src_wen[0]   = in_wen;
    src_data[0]  = in_data;
    src_tag[0]   = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_wen[k]   = wen_q[k-1];
      src_data[k]  = data_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      wen_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= src_valid[k];
          // Payload only moves with a valid entry; bubbles leave it untouched.
          if (src_valid[k]) begin
            data_q[k] <= src_data[k];
            tag_q[k]  <= src_tag[k];
            wen_q[k]  <= src_wen[k];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_wen   = wen_q[STAGES-1];

  // Scan oldest to youngest so the youngest match wins; x0 never bypasses.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (valid_q[k] && wen_q[k] && (tag_q[k] == fwd_tag) && (fwd_tag != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[k];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(valid_q[k]);
    end
  end

endmodule

// File: tb/tb_alu_result_pipe.sv
// Self-checking bench for alu_result_pipe (STAGES=2): directed vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_alu_result_pipe;

  localparam int DW = 32;
  localparam int TW = 5;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic          in_wen;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_wen;
  logic [TW-1:0] fwd_tag;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [1:0]    occupancy;

  alu_result_pipe #(.DATA_W(DW), .TAG_W(TW), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_tag(in_tag), .in_wen(in_wen), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_wen(out_wen),
    .fwd_tag(fwd_tag), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: in-flight entries oldest first, each with its current stage index.
  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          w;
    int            pos;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          w;
    logic          ordy;
    logic [TW-1:0] ft;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [1:0]    e_occ;
    logic          e_hit;
    logic [DW-1:0] e_fd;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [TW-1:0] t,
                       input logic w, input logic ordy, input logic fl, input logic [TW-1:0] ft);
    in_valid  = iv;
    in_data   = d;
    in_tag    = t;
    in_wen    = w;
    out_ready = ordy;
    flush     = fl;
    fwd_tag   = ft;
  endtask

  // An entry moves up when writeback is taking or a gap lies ahead of it.
  task automatic model_step();
    bit acc;
    if (!rst_n || flush) begin
      mq.delete();
      return;
    end
    acc = in_valid && (out_ready || mq.size() < S);
    for (int i = 0; i < mq.size(); i++) begin
      if (out_ready || (S - 1 - mq[i].pos) > i) mq[i].pos = mq[i].pos + 1;
    end
    if (mq.size() > 0 && mq[0].pos == S) void'(mq.pop_front());
    if (acc) mq.push_back('{d: in_data, t: in_tag, w: in_wen, pos: 0});
  endtask

  task automatic check_model(input string tagname);
    logic          e_ov, e_hit;
    logic [DW-1:0] e_fd;
    e_ov  = (mq.size() > 0) && (mq[0].pos == S - 1);
    e_hit = 1'b0;
    e_fd  = '0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].w && mq[i].t == fwd_tag && fwd_tag != '0) begin
        e_hit = 1'b1;
        e_fd  = mq[i].d;
      end
    end
    chk({tagname, ".out_valid"}, DW'(out_valid), DW'(e_ov));
    if (e_ov) begin
      chk({tagname, ".out_data"}, out_data, mq[0].d);
      chk({tagname, ".out_tag"}, DW'(out_tag), DW'(mq[0].t));
      chk({tagname, ".out_wen"}, DW'(out_wen), DW'(mq[0].w));
    end
    chk({tagname, ".in_ready"}, DW'(in_ready), DW'(out_ready || mq.size() < S));
    chk({tagname, ".occupancy"}, DW'(occupancy), DW'(mq.size()));
    chk({tagname, ".fwd_hit"}, DW'(fwd_hit), DW'(e_hit));
    chk({tagname, ".fwd_data"}, fwd_data, e_fd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic w);
    drive(1'b1, d, t, w, 1'b0, 1'b0, '0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst.out_valid", DW'(out_valid), 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_tag", DW'(out_tag), 0);
    chk("rst.out_wen", DW'(out_wen), 0);
    chk("rst.occupancy", DW'(occupancy), 0);
    chk("rst.fwd_hit", DW'(fwd_hit), 0);
    chk("rst.fwd_data", fwd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, then backpressure with a blocked push and a x0 query.
    vecs[0]  = '{1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h22, 5'd2, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0,  1'b1, 2'd1, 1'b1, 32'h11};
    vecs[2]  = '{1'b1, 32'h33, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 32'h11, 1'b1, 2'd2, 1'b1, 32'h22};
    vecs[3]  = '{1'b0, 32'h0,  5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 32'h22, 1'b1, 2'd2, 1'b1, 32'h33};
    vecs[4]  = '{1'b0, 32'h0,  5'd0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h33, 1'b1, 2'd1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'hA,  5'd4, 1'b1, 1'b0, 5'd4, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'hB,  5'd4, 1'b1, 1'b0, 5'd4, 1'b0, 32'h0,  1'b1, 2'd1, 1'b1, 32'hA};
    vecs[7]  = '{1'b0, 32'h0,  5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 32'hA,  1'b0, 2'd2, 1'b1, 32'hB};
    vecs[8]  = '{1'b1, 32'hD,  5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 32'hA,  1'b0, 2'd2, 1'b1, 32'hB};
    vecs[9]  = '{1'b0, 32'h0,  5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 32'hA,  1'b1, 2'd2, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0,  5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 32'hB,  1'b1, 2'd1, 1'b1, 32'hB};
    vecs[11] = '{1'b0, 32'h0,  5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 32'h0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].t, vecs[i].w, vecs[i].ordy, 1'b0, vecs[i].ft);
      #1;
      chk($sformatf("vec%0d.out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d.out_data", i), out_data, vecs[i].e_od);
      chk($sformatf("vec%0d.in_ready", i), DW'(in_ready), DW'(vecs[i].e_ir));
      chk($sformatf("vec%0d.occupancy", i), DW'(occupancy), DW'(vecs[i].e_occ));
      chk($sformatf("vec%0d.fwd_hit", i), DW'(fwd_hit), DW'(vecs[i].e_hit));
      chk($sformatf("vec%0d.fwd_data", i), fwd_data, vecs[i].e_fd);
      tick();
    end

    // Flush with an input offered while in_ready is high.
    push(32'h1, 5'd1, 1'b1);
    push(32'h2, 5'd2, 1'b1);
    drive(1'b1, 32'hC, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3);
    #1;
    chk("flush.in_ready_pre", DW'(in_ready), 1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 5'd3);
    #1;
    chk("flush.occupancy", DW'(occupancy), 0);
    chk("flush.out_valid", DW'(out_valid), 0);
    chk("flush.fwd_hit", DW'(fwd_hit), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush.no_ghost", DW'(out_valid), 0);
    end

    // Youngest match wins; a non-writing young entry defers to the older one.
    push(32'h44, 5'd7, 1'b1);
    push(32'h55, 5'd7, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd7);
    #1;
    chk("fwd.prio_hit", DW'(fwd_hit), 1);
    chk("fwd.prio_data", fwd_data, 32'h55);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd7);
    tick();
    push(32'h44, 5'd7, 1'b1);
    push(32'h55, 5'd7, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd7);
    #1;
    chk("fwd.nowen_hit", DW'(fwd_hit), 1);
    chk("fwd.nowen_data", fwd_data, 32'h44);

    // x0 never hits, and an absent tag misses.
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    push(32'h66, 5'd0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    chk("fwd.x0_hit", DW'(fwd_hit), 0);
    chk("fwd.x0_data", fwd_data, 0);
    fwd_tag = 5'd9;
    #1;
    chk("fwd.nomatch_hit", DW'(fwd_hit), 0);
    chk("fwd.nomatch_data", fwd_data, 0);

    // Asynchronous reset mid-stream.
    push(32'h77, 5'd5, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd5);
    #1;
    chk("rst2.pre_occupancy", DW'(occupancy), 2);
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    chk("rst2.out_valid", DW'(out_valid), 0);
    chk("rst2.occupancy", DW'(occupancy), 0);
    chk("rst2.fwd_hit", DW'(fwd_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst2.in_ready", DW'(in_ready), 1);
    @(negedge clk);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 2) != 0), $urandom(), TW'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0), TW'($urandom_range(0, 7)));
      #1;
      check_model("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_result_pipe.md
Name: alu_result_pipe

Overview:
- Parametrised successor to the single-stage ALU result register: an elastic chain of STAGES result registers between ALU output and writeback.
- Each stage holds a result word, its destination register tag and a write-enable, under valid/ready flow control with synchronous flush.
- Exposes a combinational forwarding port so decode/execute can bypass in-flight results before writeback.

Parameters:
- DATA_W, 32, width of the ALU result word
- TAG_W, 5, width of the destination register index
- STAGES, 2, number of pipeline register stages (legal range 1..8)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result present
- in_ready  out  1  pipe can accept the input this cycle
- in_data  in  DATA_W  ALU result
- in_tag  in  TAG_W  destination register index
- in_wen  in  1  result is to be written back
- flush  in  1  synchronous kill of all in-flight entries
- out_valid  out  1  oldest stage holds a valid entry
- out_ready  in  1  writeback consumes the output this cycle
- out_data  out  DATA_W  oldest stage result
- out_tag  out  TAG_W  oldest stage tag
- out_wen  out  1  oldest stage write-enable
- fwd_tag  in  TAG_W  register index queried by the bypass network
- fwd_hit  out  1  a valid in-flight entry writes fwd_tag
- fwd_data  out  DATA_W  youngest matching in-flight result
- occupancy  out  $clog2(STAGES+1)  number of valid stages

Behaviour:
- Stages are indexed 0 (youngest, fed by input) to STAGES-1 (oldest, drives out_*). Each stage has registers valid, data, tag, wen.
- Reset (rst_n low, asynchronous): all valid, data, tag and wen registers clear to 0. Consequently out_valid=0, out_data=0, out_tag=0, out_wen=0, occupancy=0, fwd_hit=0 and fwd_data=0. Registers hold reset while rst_n is low. Deassertion takes effect at the next rising edge.
- Ready chain (combinational): rdy[STAGES]=out_ready; rdy[k] = !valid[k] || rdy[k+1]; in_ready = rdy[0].
- in_ready does not depend on in_valid. in_ready also does not depend on flush; the flush-cycle rule below applies instead.
- Advance rule, per rising edge:
  - If rdy[k] is high, stage k loads from stage k-1. For stage 0 the source is in_valid and in_*.
  - If rdy[k] is low, stage k holds all its fields.
  - Data, tag and wen load only when the incoming valid bit is 1; otherwise they hold, and only valid is cleared.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Both may occur in the same cycle.
- Latency and throughput:
  - With out_ready held high, an accepted input appears on out_* exactly STAGES cycles later.
  - Sustained throughput is 1 entry per cycle.
  - Full pipe with out_ready=1 still accepts input (full throughput, no bubble).
- Stall: with out_ready=0, entries compact toward the output. in_ready falls only when all STAGES are valid. No entry is ever overwritten or dropped while stalled.
- out_* remain stable while out_valid=1 and out_ready=0.
- Flush:
  - On a rising edge with flush=1, every valid bit clears. Data, tag and wen hold.
  - An input presented in the flush cycle is discarded, even if in_ready was high.
  - An output handshake in the flush cycle counts as completed by writeback.
  - Flush has priority over all advance.
- Forwarding (combinational, from current register state):
  - fwd_hit=1 iff some stage k has valid=1, wen=1, tag==fwd_tag, and fwd_tag!=0. Register x0 never hits.
  - fwd_data is the data of the lowest-index (youngest) matching stage, or 0 when fwd_hit=0.
  - The input port is not forwarded; only registered stages are.
- occupancy equals the popcount of the valid bits and updates on the same edge as the valid bits.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 entries in flight -> out_valid=0, occupancy=0, fwd_hit=0 immediately; after release, in_ready=1.
- Streaming, STAGES=2, out_ready=1: inputs 0x11, 0x22, 0x33 on consecutive cycles -> outputs 0x11, 0x22, 0x33 on consecutive cycles, first appearing 2 cycles after acceptance; occupancy reaches 2.
- Backpressure: out_ready=0, push 0xA then 0xB -> in_ready=0 after the second push; out_data holds 0xA; raising out_ready -> 0xA then 0xB delivered, no loss or duplication.
- Flush: 2 entries in flight and in_valid=1 with 0xC; pulse flush -> next cycle occupancy=0 and out_valid=0; 0xC never appears at the output.
- Forwarding priority: stage0 {tag 7, 0x55, wen 1} and stage1 {tag 7, 0x44, wen 1}, fwd_tag=7 -> fwd_hit=1, fwd_data=0x55. Clear stage0 wen -> fwd_data=0x44.
- x0 and no-match: entry tag 0 with wen=1, fwd_tag=0 -> fwd_hit=0, fwd_data=0. fwd_tag=9 with no match -> fwd_hit=0.
